// File: rtl/cdb_arbiter_pkg.sv
// Shared Common Data Bus definitions used by the arbiter and its consumers (RoB, RS, LSB).
package cdb_arbiter_pkg;

    localparam int ROB_WIDTH_DEF  = 4;
    localparam int DATA_WIDTH_DEF = 32;

    typedef struct packed {
        logic                      en;
        logic [ROB_WIDTH_DEF-1:0]  index;
        logic [DATA_WIDTH_DEF-1:0] data;
    } cdb_bcast_t;

endpackage

// File: rtl/cdb_chan_fifo.sv
// Per-producer result FIFO; en freezes all state, clear empties it and wins over push/pop.
module cdb_chan_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    en,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        push_data,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (en) begin
            if (clear) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push) begin
                    mem_d[wr_ptr_q] = push_data;
                    wr_ptr_d        = wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                if (push && !pop) begin
                    count_d = count_q + CW'(1);
                end else if (pop && !push) begin
                    count_d = count_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: N producer FIFOs drained one result per cycle onto a registered broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int RoB_WIDTH  = ROB_WIDTH_DEF,
    parameter int N_SRC      = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     rdy_in,
    input  logic                                     flush_signal,
    input  logic [N_SRC-1:0]                         src_valid,
    input  logic [N_SRC*RoB_WIDTH-1:0]               src_index,
    input  logic [N_SRC*DATA_WIDTH-1:0]              src_data,
    output logic [N_SRC-1:0]                         src_ready,
    output logic                                     cdb_en,
    output logic [RoB_WIDTH-1:0]                     cdb_index,
    output logic [DATA_WIDTH-1:0]                    cdb_data,
    output logic [$clog2(N_SRC)-1:0]                 cdb_src,
    output logic [$clog2(N_SRC*FIFO_DEPTH+1)-1:0]    pending,
    output logic                                     err_overflow
);
    localparam int SW  = $clog2(N_SRC);
    localparam int SW1 = SW + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int PNW = $clog2(N_SRC*FIFO_DEPTH+1);
    localparam int EW  = RoB_WIDTH + DATA_WIDTH;

    logic [N_SRC-1:0][CW-1:0] cnt_w;
    logic [N_SRC-1:0][EW-1:0] head_w;
    logic [N_SRC-1:0]         nonempty, push, pop, err_hit;
    logic                     accept;
    logic [SW:0]              pick;
    logic                     found;
    logic [SW-1:0]            win;
    logic [SW1-1:0]           win_inc;
    logic [EW-1:0]            win_head;

    logic                  cdb_en_q, cdb_en_d;
    logic [RoB_WIDTH-1:0]  cdb_index_q, cdb_index_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [SW-1:0]         cdb_src_q, cdb_src_d;
    logic [SW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PNW-1:0]        pending_q, pending_d;
    logic                  err_q, err_d;

    // First non-empty channel at or after start, wrapping; MSB of the result flags a hit.
    function automatic logic [SW:0] rr_search(input logic [N_SRC-1:0] ne, input logic [SW-1:0] start);
        logic [SW:0]    res;
        logic [SW1-1:0] pos;
        logic [SW-1:0]  c;
        res = '0;
        for (int k = 0; k < N_SRC; k++) begin
            pos = {1'b0, start} + SW1'(k);
            if (pos >= SW1'(N_SRC)) begin
                pos = pos - SW1'(N_SRC);
            end
            c = pos[SW-1:0];
            if (!res[SW] && ne[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    assign accept = rdy_in && !flush_signal;

    for (genvar g = 0; g < N_SRC; g++) begin : g_chan
        assign nonempty[g]  = (cnt_w[g] != '0);
        assign src_ready[g] = accept && (cnt_w[g] < CW'(FIFO_DEPTH));
        assign push[g]      = src_valid[g] && src_ready[g];
        assign pop[g]       = accept && found && (win == SW'(g));
        assign err_hit[g]   = accept && src_valid[g] && !src_ready[g];

        cdb_chan_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .en        (rdy_in),
            .clear     (flush_signal),
            .push      (push[g]),
            .pop       (pop[g]),
            .push_data ({src_index[g*RoB_WIDTH +: RoB_WIDTH], src_data[g*DATA_WIDTH +: DATA_WIDTH]}),
            .head      (head_w[g]),
            .count     (cnt_w[g])
        );
    end

    assign pick     = rr_search(nonempty, rr_ptr_q);
    assign found    = pick[SW];
    assign win      = pick[SW-1:0];
    assign win_head = head_w[win];
    assign win_inc  = {1'b0, win} + SW1'(1);

    always_comb begin
        cdb_en_d    = cdb_en_q;
        cdb_index_d = cdb_index_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        pending_d   = pending_q;
        err_d       = err_q | (|err_hit);
        if (rdy_in) begin
            if (flush_signal) begin
                cdb_en_d  = 1'b0;
                rr_ptr_d  = '0;
                pending_d = '0;
            end else begin
                cdb_en_d  = found;
                pending_d = pending_q + PNW'($countones(push)) - PNW'(found);
                if (found) begin
                    cdb_index_d = win_head[EW-1 -: RoB_WIDTH];
                    cdb_data_d  = win_head[DATA_WIDTH-1:0];
                    cdb_src_d   = win;
                    rr_ptr_d    = (win_inc == SW1'(N_SRC)) ? '0 : win_inc[SW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_en_q    <= 1'b0;
            cdb_index_q <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            cdb_en_q    <= cdb_en_d;
            cdb_index_q <= cdb_index_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

    assign cdb_en       = cdb_en_q;
    assign cdb_index    = cdb_index_q;
    assign cdb_data     = cdb_data_q;
    assign cdb_src      = cdb_src_q;
    assign pending      = pending_q;
    assign err_overflow = err_q;

endmodule
